sram_mem_ctrl: RTL
==================

# sram_mem_ctrl

Sequencer between the MEM stage and an external 16-bit-wide SRAM that holds the data memory. It accepts one 32-bit word read or write from the stage, splits it into two 16-bit SRAM accesses with a programmable number of wait cycles each, and drops `ready` so the pipeline freezes until the word completes. It replaces direct single-cycle array access and keeps the same address map: byte address minus 1024, word-aligned.

## Interface
- `BASE_ADDR`, 1024: byte address of data-memory word 0.
- `SRAM_AW`, 18: SRAM halfword address width.
- `WAIT`, 2: cycles per 16-bit phase, ≥1.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_R_EN`  in  1  read request from MEM stage.
- `MEM_W_EN`  in  1  write request from MEM stage.
- `ALU_Res`  in  32  byte address.
- `Val_Rm`  in  32  write data.
- `ready`  out  1  high = no access in progress; low = freeze pipeline.
- `rdata`  out  32  last completed read word.
- `sram_addr`  out  SRAM_AW  halfword address.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  high = controller drives DQ (top level builds the tristate).
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- Word index `w = (ALU_Res - BASE_ADDR) >> 2`, 32-bit subtract; address bits [1:0] are ignored. Low half at `{w, 1'b0}`, high half at `{w, 1'b1}`, both truncated to SRAM_AW bits.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: if `MEM_W_EN | MEM_R_EN`: latch the address, `Val_Rm`, and the op; go to LOW. When both are high, the access is a write.
- LOW: drive the low-half address; the wait counter counts WAIT cycles; go to HIGH on the last count.
- HIGH: same as LOW for the high half; go to DONE on the last count.
- DONE: stays one cycle, then goes to IDLE unconditionally. Requests are not sampled in DONE. The pipeline advances in this cycle, so the same request cannot be accepted twice.
- Write: `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of LOW/HIGH. `sram_dq_out` = `Val_Rm[15:0]` in LOW and `Val_Rm[31:16]` in HIGH, taken from the latched copy.
- Read: `sram_dq_oe`=0 and `sram_we_n`=1. `sram_dq_in` is captured into `rdata[15:0]` on the last cycle of LOW and into `rdata[31:16]` on the last cycle of HIGH. `rdata` holds its value until the next read overwrites it. Writes never change `rdata`.
- `ready` = !((IDLE & (MEM_R_EN|MEM_W_EN)) | LOW | HIGH). It is combinational, so the stall starts in the same cycle as the request.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state = IDLE, counter = 0, `rdata` = 0, `sram_addr` = 0, `sram_dq_out` = 0;
  - `sram_dq_oe` = 0, `sram_we_n` = 1.
- Reset mid-access aborts the access immediately. A half-written word is acceptable; the strobe must deassert asynchronously.
- Request seen in IDLE at cycle 0. LOW occupies cycles 1..WAIT and HIGH occupies cycles WAIT+1..2·WAIT. DONE is cycle 2·WAIT+1, with `ready`=1 and `rdata` valid.
- The stall lasts 2·WAIT+1 cycles; with WAIT=2, `ready` is low for cycles 0–4.
- The earliest next request is accepted at cycle 2·WAIT+2.
- `sram_addr`, `sram_dq_out`, `sram_dq_oe`, and `sram_we_n` are registered outputs, stable for all of a phase. They are not affected by changes on the request inputs during LOW/HIGH.
- The wait counter is `$clog2(WAIT+1)` bits wide and clears on every phase entry.

## Structure
- Shared package `mem_ctrl_pkg`: state enum (IDLE/LOW/HIGH/DONE) and the `BASE_ADDR` default constant.
- One sub-module, `sram_wait_counter`: loadable down-counter with a `last` flag, parameterised by WAIT.
- FSM, latches, and output registers live in `sram_mem_ctrl`.

## Test plan
- Reset release, no requests -> `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0 indefinitely.
- Write, ALU_Res=1032, Val_Rm=0xDEADBEEF, WAIT=2 -> `sram_addr`=4 with DQ 0xBEEF for 2 cycles, then `sram_addr`=5 with DQ 0xDEAD for 2 cycles; `ready` low for 5 cycles.
- Read of ALU_Res=1032 after the above, SRAM model returning stored data -> `rdata`=0xDEADBEEF in DONE; `sram_dq_oe`=0 throughout.
- MEM_R_EN and MEM_W_EN both high, ALU_Res=1024, Val_Rm=0x12345678 -> write performed to addresses 0/1; `rdata` unchanged.
- Request held high through DONE -> exactly one access; the next access starts only at cycle 6.
- `rst` low during HIGH of a write -> `sram_we_n`=1 and state IDLE immediately; `ready`=1 after release with no request.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM data-memory controller.
//   state_t           : sequencer states (IDLE, LOW, HIGH, DONE)
//   DEFAULT_BASE_ADDR : byte address of data-memory word 0
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one 16-bit SRAM phase.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (count -> 0)
//   load : phase entry; reload so the phase lasts WAIT cycles
//   last : high on the final cycle of the phase (count == 0)
module sram_wait_counter #(
  parameter int unsigned WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int unsigned CW = $clog2(WAIT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Sequencer between the MEM stage and a 16-bit external SRAM.  Each 32-bit
// word access becomes two halfword accesses (low, then high), each lasting
// WAIT cycles; ready stays low until the word completes.
//   clk, rst        : clock, asynchronous active-low reset
//   MEM_R_EN/W_EN   : read / write request (both high = write)
//   ALU_Res         : byte address; word index = (ALU_Res - BASE_ADDR) >> 2
//   Val_Rm          : write data
//   ready           : low while an access is accepted or in progress
//   rdata           : last completed read word
//   sram_addr       : halfword address {word, half}
//   sram_dq_out/in  : SRAM data out / in
//   sram_dq_oe      : controller drives DQ
//   sram_we_n       : active-low write strobe
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned WAIT      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  output logic               ready,
  output logic [31:0]        rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_t state, next_state;
  logic   load, last, req;
  logic   op_wr;
  logic [15:0]        wdata_hi;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        off;
  logic               unused_off_bits;

  assign req = MEM_R_EN | MEM_W_EN;
  assign off = ALU_Res - BASE_ADDR;
  // Halfword address {w, half} truncated to SRAM_AW keeps off[SRAM_AW:2].
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  sram_wait_counter #(
    .WAIT(WAIT)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .load(load),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        next_state = LOW;
        load       = 1'b1;
      end
      LOW: if (last) begin
        next_state = HIGH;
        load       = 1'b1;
      end
      HIGH: if (last) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ready = !(((state == IDLE) && req) || (state == LOW) || (state == HIGH));

  // Outputs are registered on phase entry.  The low-half data is taken from
  // Val_Rm in the accept cycle, which is the same value being latched, so
  // only the high half needs a held copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr       <= 1'b0;
      wdata_hi    <= '0;
      word        <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          op_wr       <= MEM_W_EN;
          wdata_hi    <= Val_Rm[31:16];
          word        <= off[SRAM_AW:2];
          sram_addr   <= {off[SRAM_AW:2], 1'b0};
          sram_dq_out <= Val_Rm[15:0];
          sram_dq_oe  <= MEM_W_EN;
          sram_we_n   <= !MEM_W_EN;
        end
        LOW: if (last) begin
          if (!op_wr) rdata[15:0] <= sram_dq_in;
          sram_addr   <= {word, 1'b1};
          sram_dq_out <= wdata_hi;
        end
        HIGH: if (last) begin
          if (!op_wr) rdata[31:16] <= sram_dq_in;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
